// File: rtl/ghost_scheduler_if.sv
// Handshake bundle between ghost_scheduler and the score/collision and ghost datapath logic.
interface ghost_scheduler_if;
    logic        start;
    logic [13:0] score;
    logic [9:0]  y_y;
    logic        collision;
    logic        step_top;
    logic        step_bottom;
    logic        chase_top;
    logic        chase_bottom;
    logic        respawn;
    logic        face_top;
    logic        face_bottom;
    logic [1:0]  lives;
    logic        game_over;

    modport master (
        output start, score, y_y, collision,
        input  step_top, step_bottom, chase_top, chase_bottom, respawn,
               face_top, face_bottom, lives, game_over
    );

    modport slave (
        input  start, score, y_y, collision,
        output step_top, step_bottom, chase_top, chase_bottom, respawn,
               face_top, face_bottom, lives, game_over
    );
endinterface

// File: rtl/ghost_scheduler.sv
// Ghost step/chase sequencer with spawn/hit/game-over FSM and score-scaled step period.
// Optional face animation is enabled by defining GHOST_FACE_ANIM_EN.
module ghost_scheduler #(
    parameter int BASE_PERIOD = 4600000,
    parameter int MIN_PERIOD  = 1000000,
    parameter int SCORE_STEP  = 200,
    parameter int SPLIT_Y     = 297,
    parameter int SPAWN_TICKS = 64,
    parameter int HIT_TICKS   = 128,
    parameter int LIVES       = 3,
    parameter int FACE_PERIOD = 40000000
) (
    input  logic              clk,
    input  logic              reset,
    ghost_scheduler_if.slave  bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SPAWN = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_HIT   = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;

    localparam int TICK_MAX = (SPAWN_TICKS > HIT_TICKS) ? SPAWN_TICKS : HIT_TICKS;
    localparam int TCNT_W   = $clog2(TICK_MAX + 1);

    logic [2:0]        state;
    logic [2:0]        state_nx;
    logic [25:0]       cnt_p0;
    logic [25:0]       period_q;
    logic [TCNT_W-1:0] tcnt;
    logic [1:0]        lives_q;
    logic              running;
    logic              tick;
    logic              respawn_q;
    logic              step_top_p1;
    logic              step_bottom_p2;
    logic              chase_top_q;
    logic              chase_bottom_q;

    // Saturating score offset, clamped so the period never drops below MIN_PERIOD.
    function automatic logic [25:0] calc_period(input logic [13:0] score);
        logic [39:0] prod;
        logic [25:0] off;
        prod = 40'(score) * 40'(SCORE_STEP);
        off  = (prod > 40'(26'h3FF_FFFF)) ? 26'h3FF_FFFF : prod[25:0];
        if (off >= 26'(BASE_PERIOD - MIN_PERIOD))
            return 26'(MIN_PERIOD);
        else
            return 26'(BASE_PERIOD) - off;
    endfunction

    assign running = (state == S_SPAWN) || (state == S_RUN) || (state == S_HIT);
    assign tick    = running && (cnt_p0 == period_q - 26'd1);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_OVER: if (bus.start) state_nx = S_SPAWN;
            S_SPAWN: if (tick && tcnt == TCNT_W'(SPAWN_TICKS - 1)) state_nx = S_RUN;
            S_RUN:   if (bus.collision) state_nx = S_HIT;
            S_HIT:   if (tick && tcnt == TCNT_W'(HIT_TICKS - 1))
                         state_nx = (lives_q == 2'd0) ? S_OVER : S_SPAWN;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            cnt_p0         <= '0;
            period_q       <= 26'(BASE_PERIOD);
            tcnt           <= '0;
            lives_q        <= 2'd0;
            respawn_q      <= 1'b0;
            step_top_p1    <= 1'b0;
            step_bottom_p2 <= 1'b0;
            chase_top_q    <= 1'b0;
            chase_bottom_q <= 1'b0;
        end else begin
            state     <= state_nx;
            respawn_q <= (state_nx == S_SPAWN) && (state != S_SPAWN);

            // Counter restarts on every state entry; period_q only changes at a wrap.
            if (state_nx != state || !running) begin
                cnt_p0 <= '0;
                tcnt   <= '0;
            end else if (tick) begin
                cnt_p0 <= '0;
                tcnt   <= tcnt + TCNT_W'(1);
            end else begin
                cnt_p0 <= cnt_p0 + 26'd1;
            end
            if (tick) period_q <= calc_period(bus.score);

            if ((state == S_IDLE || state == S_OVER) && bus.start)
                lives_q <= 2'(LIVES);
            else if (state == S_RUN && bus.collision)
                lives_q <= (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;

            // tick -> step_top -> step_bottom; a collision cancels whatever is pending
            step_top_p1    <= (state == S_RUN) && tick && !bus.collision;
            step_bottom_p2 <= step_top_p1 && !((state == S_RUN) && bus.collision);

            chase_bottom_q <= (state == S_RUN) && (bus.y_y >= 10'(SPLIT_Y));
            chase_top_q    <= (state == S_RUN) && (bus.y_y <  10'(SPLIT_Y));
        end
    end

    assign bus.step_top     = step_top_p1;
    assign bus.step_bottom  = step_bottom_p2;
    assign bus.chase_top    = chase_top_q;
    assign bus.chase_bottom = chase_bottom_q;
    assign bus.respawn      = respawn_q;
    assign bus.lives        = lives_q;
    assign bus.game_over    = (state == S_OVER);

`ifdef GHOST_FACE_ANIM_EN
    logic [25:0] face_cnt;
    logic        phase;
    logic        face_top_q;
    logic        face_bottom_q;

    assign phase = (face_cnt >= 26'(FACE_PERIOD / 2));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            face_cnt      <= '0;
            face_top_q    <= 1'b0;
            face_bottom_q <= 1'b0;
        end else begin
            face_cnt      <= (face_cnt == 26'(FACE_PERIOD - 1)) ? 26'd0 : face_cnt + 26'd1;
            face_top_q    <= phase & chase_top_q;
            face_bottom_q <= phase & chase_bottom_q;
        end
    end

    assign bus.face_top    = face_top_q;
    assign bus.face_bottom = face_bottom_q;
`else
    // Keeps FACE_PERIOD referenced when the animation is compiled out.
    logic unused_face_cfg;
    assign unused_face_cfg = ^FACE_PERIOD;
    assign bus.face_top    = 1'b0;
    assign bus.face_bottom = 1'b0;
`endif

endmodule

// File: doc/ghost_scheduler.md
# ghost_scheduler

Central sequencer for the ghost sprites. It generates single-cycle, clk-synchronous step enables for the top and bottom ghosts at a score-dependent rate, and decides which ghost may chase based on Yoshi's vertical region. It also runs the spawn / hit / game-over state machine with a lives counter. It sits between the score/collision logic and the ghost_top and ghost_bottom datapaths, replacing their free-running local tick counters.

## Interface
Parameters:
- BASE_PERIOD, 4600000, step period in clk cycles at score 0
- MIN_PERIOD, 1000000, lower clamp on the step period
- SCORE_STEP, 200, cycles removed from the period per score point
- SPLIT_Y, 297, Yoshi y at or above which the bottom ghost chases
- SPAWN_TICKS, 64, step periods held in SPAWN before chasing
- HIT_TICKS, 128, step periods frozen after a collision
- LIVES, 3, lives loaded on start (2-bit counter, 1..3)
- FACE_PERIOD, 40000000, face-animation period in clk cycles

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  level or pulse; begins a game from IDLE or OVER
- score  in  14  current score, unsigned
- y_y  in  10  Yoshi top-left y
- collision  in  1  Yoshi-ghost overlap, any ghost
- step_top, step_bottom  out  1  one-cycle move enables
- chase_top, chase_bottom  out  1  ghost allowed to move toward Yoshi
- respawn  out  1  one-cycle pulse; ghosts reload start positions
- face_top, face_bottom  out  1  alternate-face select
- lives  out  2  remaining lives
- game_over  out  1  high in OVER

## Operation
- States: IDLE, SPAWN, RUN, HIT, OVER. Reset enters IDLE.
- IDLE: on start, go to SPAWN, load lives=LIVES, pulse respawn.
- SPAWN: count SPAWN_TICKS period ticks, then go to RUN.
- RUN: on each period tick, issue step_top, then step_bottom.
  - A ghost is only moved by its datapath when its chase signal is high.
  - On collision, go to HIT and decrement lives.
- HIT: no steps; count HIT_TICKS ticks.
  - If lives==0, go to OVER.
  - Otherwise go to SPAWN and pulse respawn.
- OVER: game_over=1. On start, go to SPAWN, reload lives, pulse respawn.
- Period calculation:
  - offset = score*SCORE_STEP, computed at 26 bits, saturating.
  - period = max(BASE_PERIOD - offset, MIN_PERIOD). No underflow is permitted.
- The period is latched into period_q only when the counter wraps, so a score change never truncates or overruns the current period.
- Period counter: 26 bits, counts 0..period_q-1, then wraps. It runs in SPAWN, RUN and HIT, and is cleared in IDLE/OVER and on every state entry.
- Chase: in RUN only, chase_bottom = (y_y >= SPLIT_Y) and chase_top = !chase_bottom. Both are 0 in other states.
- start is ignored in SPAWN, RUN and HIT.
- collision is ignored outside RUN.

## Timing
- Reset values: all outputs 0, lives=0, state IDLE, counters 0, period_q=BASE_PERIOD.
- Tick: the cycle in which counter==period_q-1.
  - step_top is high in the cycle after the tick (registered).
  - step_bottom is high one cycle after step_top. They are never coincident.
- Collision versus steps:
  - If collision arrives in the tick cycle, collision wins and no steps issue.
  - If collision arrives while step_bottom is pending, step_bottom is suppressed.
- respawn is high in the first cycle of SPAWN.
- chase_* are registered from y_y, with 1-cycle latency.
- State transitions occur on the clk edge after the qualifying condition.
- lives decrements in the HIT entry cycle. It saturates at 0.
- reset asserted mid-game returns everything to reset values immediately (asynchronous).

## Configuration
- GHOST_FACE_ANIM_EN defined:
  - A 26-bit face counter wraps at FACE_PERIOD-1.
  - phase = counter >= FACE_PERIOD/2.
  - face_top = phase & chase_top, face_bottom = phase & chase_bottom. Both are registered.
- GHOST_FACE_ANIM_EN undefined: face_top and face_bottom are tied to 0 and no face counter is built.

## Test plan
Bench parameters: BASE_PERIOD=20, MIN_PERIOD=8, SCORE_STEP=2, SPAWN_TICKS=2, HIT_TICKS=3, LIVES=2, FACE_PERIOD=10.
- Reset, then pulse start -> respawn high for 1 cycle and lives=2. After 40 cycles RUN is entered. step_top then recurs every 20 cycles, with step_bottom exactly 1 cycle after each step_top.
- score=5 mid-period -> the current period completes at 20 cycles, later periods are 10. score=100 -> the period clamps at 8.
- y_y=300 in RUN -> chase_bottom=1, chase_top=0 after 1 cycle. y_y=296 -> the reverse.
- collision in the same cycle as a tick -> no step pulses, state HIT, lives=1. After 60 cycles respawn pulses and SPAWN is entered.
- Second collision -> lives=0. After HIT, game_over=1 and no steps occur. start -> lives=2, respawn pulses.
- With GHOST_FACE_ANIM_EN defined and chase_bottom=1 -> face_bottom toggles with a 5-high / 5-low pattern. Undefined -> face_bottom stays 0.
